multiplier_datapath_taint_word: RTL and testbench

- Datapath stage of the sequential shift-add multiplier. It sits directly downstream of the multiplier control FSM.
- Consumes the control strobes (mdld, mrld, rsclear, rsload, rsshr, productDone) and their taint bits.
- Holds the multiplicand, multiplier and running-sum registers. Feeds multiplierReg and multiplierReg_t back to the control FSM.
- Taint is tracked at word granularity: one taint bit per register.

---
 rtl/multiplier_datapath_taint_word.sv | 152 +++++++++++++++
 tb/tb_multiplier_datapath_taint_word.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multiplier_datapath_taint_word.sv
// ---------------------------------------------------------------------------
// multiplier_datapath_taint_word
//
// Datapath stage of a sequential shift-add multiplier with word-granularity
// taint tracking (one taint bit per register). Sits downstream of the
// multiplier control FSM, which drives the strobes and reads back
// multiplierReg / multiplierReg_t.
//
// Optional feature macro: TAINT_CONSERVATIVE_CTRL_EN
//   undefined : a strobe taint counts only while its strobe is asserted
//   defined   : any tainted strobe taints its target, asserted or not
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   multiplicand / multiplicand_t   operand A and its taint
//   multiplier / multiplier_t       operand B and its taint
//   mdld, mrld (+ _t)               load multiplicand / multiplier register
//   rsclear, rsload, rsshr (+ _t)   running-sum ops (clear > load > shift)
//   productDone / productDone_t     capture the product this cycle
//   multiplierReg / multiplierReg_t multiplier register back to the FSM
//   product / product_t             captured 2*WIDTH-bit product and taint
//   product_valid / product_valid_t one-cycle capture pulse and its taint
// ---------------------------------------------------------------------------
module multiplier_datapath_taint_word #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic               mdld,
    input  logic               mdld_t,
    input  logic               mrld,
    input  logic               mrld_t,
    input  logic               rsclear,
    input  logic               rsclear_t,
    input  logic               rsload,
    input  logic               rsload_t,
    input  logic               rsshr,
    input  logic               rsshr_t,
    input  logic               productDone,
    input  logic               productDone_t,
    output logic [WIDTH-1:0]   multiplierReg,
    output logic               multiplierReg_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               product_valid,
    output logic               product_valid_t
);

    localparam int RSW = 2 * WIDTH + 1;

    logic [WIDTH-1:0]   md_r;
    logic [WIDTH-1:0]   mr_r;
    logic [RSW-1:0]     rs_r;
    logic               md_t_r;
    logic               mr_t_r;
    logic               rs_t_r;
    logic [2*WIDTH-1:0] product_r;
    logic               product_t_r;
    logic               product_valid_r;
    logic               product_valid_t_r;

    logic [RSW-1:0]     rs_next_s;
    logic               rs_data_t_s;
    logic               rs_t_next_s;
    logic               md_t_next_s;
    logic               mr_t_next_s;

    // Control-taint term: how much a strobe's taint contributes to its target.
    function automatic logic ctrl_taint(input logic s, input logic s_t);
`ifdef TAINT_CONSERVATIVE_CTRL_EN
        return s_t;
`else
        return s & s_t;
`endif
    endfunction

    // Running-sum next value and data taint, priority clear > load > shift.
    always_comb begin
        rs_next_s   = rs_r;
        rs_data_t_s = rs_t_r;
        if (rsclear) begin
            rs_next_s   = {RSW{1'b0}};
            rs_data_t_s = 1'b0;
        end else if (rsload) begin
            // W+1-bit add into the upper half; bit 2W keeps the carry.
            rs_next_s[2*WIDTH:WIDTH] = {1'b0, rs_r[2*WIDTH-1:WIDTH]} + {1'b0, md_r};
            rs_data_t_s              = rs_t_r | md_t_r;
        end else if (rsshr) begin
            rs_next_s   = {1'b0, rs_r[RSW-1:1]};
            rs_data_t_s = rs_t_r;
        end else begin
            rs_next_s   = rs_r;
            rs_data_t_s = rs_t_r;
        end
    end

    // Register taints; losing strobes still contribute their control term.
    always_comb begin
        rs_t_next_s = ctrl_taint(rsclear, rsclear_t) | ctrl_taint(rsload, rsload_t)
                    | ctrl_taint(rsshr, rsshr_t) | rs_data_t_s;
        md_t_next_s = ctrl_taint(mdld, mdld_t) | (mdld ? multiplicand_t : md_t_r);
        mr_t_next_s = ctrl_taint(mrld, mrld_t) | (mrld ? multiplier_t : mr_t_r);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_r              <= {WIDTH{1'b0}};
            mr_r              <= {WIDTH{1'b0}};
            rs_r              <= {RSW{1'b0}};
            md_t_r            <= 1'b0;
            mr_t_r            <= 1'b0;
            rs_t_r            <= 1'b0;
            product_r         <= {(2*WIDTH){1'b0}};
            product_t_r       <= 1'b0;
            product_valid_r   <= 1'b0;
            product_valid_t_r <= 1'b0;
        end else begin
            if (mdld) begin
                md_r <= multiplicand;
            end
            if (mrld) begin
                mr_r <= multiplier;
            end
            md_t_r <= md_t_next_s;
            mr_t_r <= mr_t_next_s;
            rs_r   <= rs_next_s;
            rs_t_r <= rs_t_next_s;
            // Capture sees this cycle's rs update, so the final shift is included.
            if (productDone) begin
                product_r       <= rs_next_s[2*WIDTH-1:0];
                product_t_r     <= rs_t_next_s | productDone_t;
                product_valid_r <= 1'b1;
            end else begin
                product_valid_r <= 1'b0;
            end
            product_valid_t_r <= ctrl_taint(productDone, productDone_t);
        end
    end

    assign multiplierReg   = mr_r;
    assign multiplierReg_t = mr_t_r;
    assign product         = product_r;
    assign product_t       = product_t_r;
    assign product_valid   = product_valid_r;
    assign product_valid_t = product_valid_t_r;

endmodule

// File: tb/tb_multiplier_datapath_taint_word.sv
module tb_multiplier_datapath_taint_word;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] multiplicand = '0;
    logic multiplicand_t = 1'b0;
    logic [W-1:0] multiplier = '0;
    logic multiplier_t = 1'b0;
    logic mdld = 1'b0, mdld_t = 1'b0, mrld = 1'b0, mrld_t = 1'b0;
    logic rsclear = 1'b0, rsclear_t = 1'b0, rsload = 1'b0, rsload_t = 1'b0;
    logic rsshr = 1'b0, rsshr_t = 1'b0, productDone = 1'b0, productDone_t = 1'b0;
    logic [W-1:0] multiplierReg;
    logic multiplierReg_t;
    logic [2*W-1:0] product;
    logic product_t, product_valid, product_valid_t;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        logic           prod_t;
        logic           valid_t;
    } exp_t;
    exp_t sb[$];

    multiplier_datapath_taint_word #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
        .rsclear(rsclear), .rsclear_t(rsclear_t),
        .rsload(rsload), .rsload_t(rsload_t),
        .rsshr(rsshr), .rsshr_t(rsshr_t),
        .productDone(productDone), .productDone_t(productDone_t),
        .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
        .product(product), .product_t(product_t),
        .product_valid(product_valid), .product_valid_t(product_valid_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every capture pulse is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && product_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_capture: got product %0h expected no pulse", product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", {24'd0, product}, {24'd0, e.prod});
                chk("product_t", {31'd0, product_t}, {31'd0, e.prod_t});
                chk("product_valid_t", {31'd0, product_valid_t}, {31'd0, e.valid_t});
            end
        end
    end

    // Advance one clock, then return every strobe and strobe taint to 0.
    task automatic tick();
        @(posedge clk);
        #1;
        mdld = 1'b0; mdld_t = 1'b0; mrld = 1'b0; mrld_t = 1'b0;
        rsclear = 1'b0; rsclear_t = 1'b0; rsload = 1'b0; rsload_t = 1'b0;
        rsshr = 1'b0; rsshr_t = 1'b0; productDone = 1'b0; productDone_t = 1'b0;
        multiplicand_t = 1'b0; multiplier_t = 1'b0;
    endtask

    task automatic push(input logic [2*W-1:0] p, input logic pt, input logic vt);
        exp_t e;
        e.prod = p; e.prod_t = pt; e.valid_t = vt;
        sb.push_back(e);
    endtask

    // Full multiply: INIT, then per bit an optional load and a shift.
    task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic at, input logic bt, input logic mrt,
                        input logic clrt, input logic ldt, input logic pdt);
        int unsigned ref_prod;
        logic ref_t;
        ref_prod = a * b;
        // Taint reaches rs from the clear strobe, any tainted load strobe,
        // or the multiplicand once it has actually been added in.
        ref_t = clrt | (ldt && b != 0) | (at && b != 0) | pdt;
        multiplicand = a; multiplier = b; multiplicand_t = at; multiplier_t = bt;
        mdld = 1'b1; mrld = 1'b1; mrld_t = mrt; rsclear = 1'b1; rsclear_t = clrt;
        tick();
        chk("multiplierReg", {28'd0, multiplierReg}, {28'd0, b});
        chk("multiplierReg_t", {31'd0, multiplierReg_t}, {31'd0, bt | mrt});
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                rsload = 1'b1; rsload_t = ldt;
                tick();
            end
            rsshr = 1'b1;
            if (i == W - 1) begin
                productDone = 1'b1; productDone_t = pdt;
                push(ref_prod[2*W-1:0], ref_t, pdt);
            end
            tick();
        end
        chk("valid_pulse_hi", {31'd0, product_valid}, 32'd1);
        tick();
        chk("valid_pulse_lo", {31'd0, product_valid}, 32'd0);
    endtask

    initial begin
        logic cons;
`ifdef TAINT_CONSERVATIVE_CTRL_EN
        cons = 1'b1;
`else
        cons = 1'b0;
`endif
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_multiplierReg", {28'd0, multiplierReg}, 32'd0);
        chk("rst_product", {24'd0, product}, 32'd0);
        chk("rst_valid", {31'd0, product_valid}, 32'd0);

        mult(4'd13, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("direct_143", {24'd0, product}, 32'h8F);
        mult(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mult(4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mult(4'd9, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mult(4'd6, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
        end

        // Reset mid-operation, with strobes asserted in the reset cycle.
        multiplicand = 4'd9; multiplier = 4'd7; multiplicand_t = 1'b1; multiplier_t = 1'b1;
        mdld = 1'b1; mrld = 1'b1; rsclear = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            rsload = 1'b1; tick();
            rsshr = 1'b1; tick();
        end
        rst = 1'b1; rsload = 1'b1; mdld = 1'b1; mrld = 1'b1; productDone = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_mr", {28'd0, multiplierReg}, 32'd0);
        chk("rst_mid_mr_t", {31'd0, multiplierReg_t}, 32'd0);
        chk("rst_mid_product", {24'd0, product}, 32'd0);
        chk("rst_mid_product_t", {31'd0, product_t}, 32'd0);
        chk("rst_mid_valid", {31'd0, product_valid}, 32'd0);
        chk("rst_mid_valid_t", {31'd0, product_valid_t}, 32'd0);
        // A load captured now exposes md and rs: both must be zero and clean.
        rsload = 1'b1; productDone = 1'b1;
        push(8'h00, 1'b0, 1'b0);
        tick();
        tick();

        // Clear beats load even with a nonzero multiplicand held.
        mult(4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rsclear = 1'b1; rsload = 1'b1; productDone = 1'b1;
        push(8'h00, 1'b0, 1'b0);
        tick();
        tick();

        // Tainted but deasserted shift strobe.
        rsshr_t = 1'b1; productDone = 1'b1;
        push(8'h00, cons, 1'b0);
        tick();
        productDone = 1'b1;
        push(8'h00, cons, 1'b0);
        tick();
        tick();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
